fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle RV32I core. It owns the program counter and issues one instruction-memory request at a time over a valid/ready handshake. It presents the fetched instruction, its PC and PC+4 to decode through a second valid/ready handshake. It accepts redirects (branch/jump targets produced by the PC target adder), squashing any in-flight or held fetch.

---
 rtl/fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32I instruction fetch stage. Owns the PC, issues one imem
//            request at a time and hands fetched instructions to decode over
//            a valid/ready handshake. Redirects squash in-flight fetches.
// Options  : FETCH_MISALIGN_CHECK_EN - trap misaligned redirect targets into
//            a sticky FAULT state instead of silently aligning them.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic        misalign_fault
);

    localparam logic [31:0] c_nop       = 32'h0000_0013;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus4;
    logic [31:0] r_if_instr;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_req_pc_nxt;
    logic        w_if_valid_nxt;
    logic        w_load_if;
    logic        w_req_hs;
    logic        w_fault_nxt;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic        r_fault;
    logic        w_redir_bad;
    assign w_redir_bad    = (redirect_pc[1:0] != 2'b00);
    assign misalign_fault = r_fault;
`else
    assign misalign_fault = 1'b0;
`endif

    // Request side is purely a function of state and pc; suppressed in reset.
    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign imem_req_addr  = r_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;

    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign if_instr    = r_if_instr;

    // Next-state logic: normal flow first, then a redirect overrides it.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_pc_nxt   = r_req_pc;
        w_if_valid_nxt = r_if_valid;
        w_load_if      = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        w_fault_nxt    = r_fault;
`else
        w_fault_nxt    = 1'b0;
`endif

        case (r_state)
            S_REQ: begin
                if (w_req_hs) begin
                    w_req_pc_nxt = r_pc;
                    w_pc_nxt     = r_pc + 32'd4;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_load_if      = 1'b1;
                    w_if_valid_nxt = 1'b1;
                    w_state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (if_ready) begin
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        // A fault is sticky until reset, so redirects are ignored there.
        if (redirect_valid && (r_state != S_FAULT)) begin
            w_if_valid_nxt = 1'b0;
            w_load_if      = 1'b0;
            w_pc_nxt       = redirect_pc & c_word_mask;
            // A request still owed a response must drain before the next one.
            case (r_state)
                S_REQ:   w_state_nxt = w_req_hs       ? S_DRAIN : S_REQ;
                S_WAIT:  w_state_nxt = imem_rsp_valid ? S_REQ   : S_DRAIN;
                S_DRAIN: w_state_nxt = imem_rsp_valid ? S_REQ   : S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if (w_redir_bad) begin
                w_fault_nxt = 1'b1;
                w_state_nxt = S_FAULT;
            end
`endif
        end
    end

    // State, PC and decode-facing output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_req_pc      <= 32'd0;
            r_if_valid    <= 1'b0;
            r_if_pc       <= 32'd0;
            r_if_pc_plus4 <= 32'd0;
            r_if_instr    <= c_nop;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            if (w_load_if) begin
                r_if_pc       <= r_req_pc;
                r_if_pc_plus4 <= r_req_pc + 32'd4;
                r_if_instr    <= imem_rsp_data;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky misaligned-redirect flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_nxt;
        end
    end
`else
    logic w_unused_fault;
    assign w_unused_fault = w_fault_nxt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a simple
//            one-cycle instruction memory model that can be switched off
//            for hand-driven delayed responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        misalign_fault;

    int n_checks = 0;
    int n_errors = 0;
    bit auto_mem;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr),
        .misalign_fault (misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the memory model returns for a given address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA500_0013;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; the memory model answers an accepted request next cycle.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rsp_valid = hs;
            imem_rsp_data  = hs ? instr_of(a) : 32'h0;
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b1;
        auto_mem       = 1'b1;

        // Reset values
        tick();
        tick();
        check_val("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_val("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check_val("rst_if_pc", if_pc, 32'h0);
        check_val("rst_if_pc4", if_pc_plus4, 32'h0);
        check_val("rst_if_instr", if_instr, 32'h0000_0013);
        check_val("rst_fault", {31'd0, misalign_fault}, 32'd0);
        rst = 1'b0;
        #1;
        check_val("first_req_valid", {31'd0, imem_req_valid}, 32'd1);

        // Sequential fetch, one instruction every three cycles
        for (int i = 0; i < 3; i++) begin
            check_val("seq_req_addr", imem_req_addr, 32'(i * 4));
            tick();
            check_val("seq_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
            tick();
            check_val("seq_if_valid", {31'd0, if_valid}, 32'd1);
            check_val("seq_if_pc", if_pc, 32'(i * 4));
            check_val("seq_if_pc4", if_pc_plus4, 32'(i * 4 + 4));
            check_val("seq_if_instr", if_instr, instr_of(32'(i * 4)));
            tick();
        end

        // Decode stall for five cycles in HOLD
        check_val("stall_req_addr", imem_req_addr, 32'hC);
        tick();
        if_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_val("stall_if_valid", {31'd0, if_valid}, 32'd1);
            check_val("stall_if_pc", if_pc, 32'hC);
            check_val("stall_if_instr", if_instr, instr_of(32'hC));
            check_val("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
            if (i < 4) tick();
        end
        if_ready = 1'b1;
        #1;
        check_val("stall_release_noreq", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check_val("stall_next_req", {31'd0, imem_req_valid}, 32'd1);
        check_val("stall_next_addr", imem_req_addr, 32'h10);
        check_val("stall_next_ifv", {31'd0, if_valid}, 32'd0);

        // Redirect in WAIT with a response delayed by three cycles
        auto_mem = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check_val("drain_noreq", {31'd0, imem_req_valid}, 32'd0);
        check_val("drain_ifv", {31'd0, if_valid}, 32'd0);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0BAD;
        #1;
        check_val("drain_rsp_noreq", {31'd0, imem_req_valid}, 32'd0);
        tick();
        imem_rsp_valid = 1'b0;
        auto_mem       = 1'b1;
        check_val("drop_ifv", {31'd0, if_valid}, 32'd0);
        check_val("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check_val("redir_req_addr", imem_req_addr, 32'h100);
        tick();
        tick();
        check_val("redir_if_pc", if_pc, 32'h100);
        check_val("redir_if_instr", if_instr, instr_of(32'h100));
        tick();
        check_val("redir_next_addr", imem_req_addr, 32'h104);

        // Redirect on the same cycle as the request handshake at 0x8
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        tick();
        redirect_valid = 1'b0;
        check_val("nohs_redir_addr", imem_req_addr, 32'h8);
        check_val("nohs_redir_valid", {31'd0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check_val("hs_redir_noreq", {31'd0, imem_req_valid}, 32'd0);
        check_val("hs_redir_ifv", {31'd0, if_valid}, 32'd0);
        tick();
        check_val("hs_redir_ifv2", {31'd0, if_valid}, 32'd0);
        check_val("hs_redir_addr", imem_req_addr, 32'h200);
        tick();
        tick();
        check_val("hs_redir_if_valid", {31'd0, if_valid}, 32'd1);
        check_val("hs_redir_if_pc", if_pc, 32'h200);
        check_val("hs_redir_if_instr", if_instr, instr_of(32'h200));

        // Redirect out of HOLD to the top word; PC wraps to zero
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check_val("wrap_ifv_drop", {31'd0, if_valid}, 32'd0);
        check_val("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check_val("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check_val("wrap_if_pc4", if_pc_plus4, 32'h0);
        tick();
        check_val("wrap_next_addr", imem_req_addr, 32'h0);

        // Misaligned redirect
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            check_val("mis_fault", {31'd0, misalign_fault}, 32'd1);
            check_val("mis_noreq", {31'd0, imem_req_valid}, 32'd0);
            tick();
        end
`else
        check_val("mis_fault", {31'd0, misalign_fault}, 32'd0);
        check_val("mis_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check_val("mis_req_addr", imem_req_addr, 32'h100);
`endif

        // Reset in mid-operation
        imem_req_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check_val("mid_rst_noreq", {31'd0, imem_req_valid}, 32'd0);
        check_val("mid_rst_ifv", {31'd0, if_valid}, 32'd0);
        check_val("mid_rst_instr", if_instr, 32'h0000_0013);
        check_val("mid_rst_fault", {31'd0, misalign_fault}, 32'd0);
        rst = 1'b0;
        #1;
        check_val("mid_rst_req", {31'd0, imem_req_valid}, 32'd1);
        check_val("mid_rst_addr", imem_req_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
